// File: rtl/exe_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exe_stage_pkg : widths, ALU op bit indices, payload type and states        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package exe_stage_pkg;

   localparam int ES_XLEN = 32;
   localparam int ES_OP_W = 19;
   localparam int GPR_W   = 5;

   localparam int OP_ADD   = 0;
   localparam int OP_SUB   = 1;
   localparam int OP_SLT   = 2;
   localparam int OP_SLTU  = 3;
   localparam int OP_AND   = 4;
   localparam int OP_NOR   = 5;
   localparam int OP_OR    = 6;
   localparam int OP_XOR   = 7;
   localparam int OP_SLL   = 8;
   localparam int OP_SRL   = 9;
   localparam int OP_SRA   = 10;
   localparam int OP_LUI   = 11;
   localparam int OP_MUL   = 12;
   localparam int OP_MULH  = 13;
   localparam int OP_MULHU = 14;
   localparam int OP_DIV   = 15;
   localparam int OP_DIVU  = 16;
   localparam int OP_MOD   = 17;
   localparam int OP_MODU  = 18;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY,
      DONE = ST_DONE
   } es_state_e;

   typedef struct packed {
      logic [ES_OP_W-1:0] op;
      logic [ES_XLEN-1:0] src1;
      logic [ES_XLEN-1:0] src2;
      logic [ES_XLEN-1:0] pc;
      logic [ES_XLEN-1:0] st_data;
      logic [GPR_W-1:0]   dest;
      logic               gr_we;
      logic               res_from_mem;
      logic               mem_we;
   } es_payload_t;

endpackage
`default_nettype wire

// File: rtl/exe_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exe_stage_if : decode, ALU, memory-stage and forwarding signals of EXE     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface exe_stage_if
   import exe_stage_pkg::*;
#(
   parameter int OP_W = ES_OP_W,
   parameter int XLEN = ES_XLEN
);
   logic             flush;
   logic             ds_to_es_valid;
   logic             es_allowin;
   logic [OP_W-1:0]  ds_alu_op;
   logic [XLEN-1:0]  ds_src1;
   logic [XLEN-1:0]  ds_src2;
   logic [XLEN-1:0]  ds_pc;
   logic [GPR_W-1:0] ds_dest;
   logic             ds_gr_we;
   logic             ds_res_from_mem;
   logic             ds_mem_we;
   logic [XLEN-1:0]  ds_st_data;
   logic [OP_W-1:0]  alu_op;
   logic [XLEN-1:0]  alu_src1;
   logic [XLEN-1:0]  alu_src2;
   logic [XLEN-1:0]  alu_result;
   logic             alu_complete;
   logic             es_to_ms_valid;
   logic             ms_allowin;
   logic [XLEN-1:0]  es_pc;
   logic [XLEN-1:0]  es_result;
   logic [XLEN-1:0]  es_st_data;
   logic [GPR_W-1:0] es_dest;
   logic             es_gr_we;
   logic             es_res_from_mem;
   logic             es_mem_we;
   logic             es_fwd_valid;
   logic [GPR_W-1:0] es_fwd_dest;
   logic             es_fwd_stall;

   modport slave (
      input  flush, ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_pc, ds_dest,
             ds_gr_we, ds_res_from_mem, ds_mem_we, ds_st_data,
             alu_result, alu_complete, ms_allowin,
      output es_allowin, alu_op, alu_src1, alu_src2, es_to_ms_valid,
             es_pc, es_result, es_st_data, es_dest, es_gr_we, es_res_from_mem,
             es_mem_we, es_fwd_valid, es_fwd_dest, es_fwd_stall
   );

   modport master (
      output flush, ds_to_es_valid, ds_alu_op, ds_src1, ds_src2, ds_pc, ds_dest,
             ds_gr_we, ds_res_from_mem, ds_mem_we, ds_st_data,
             alu_result, alu_complete, ms_allowin,
      input  es_allowin, alu_op, alu_src1, alu_src2, es_to_ms_valid,
             es_pc, es_result, es_st_data, es_dest, es_gr_we, es_res_from_mem,
             es_mem_we, es_fwd_valid, es_fwd_dest, es_fwd_stall
   );

endinterface
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exe_stage : holds one decoded instruction until the shared ALU completes   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module exe_stage
   import exe_stage_pkg::*;
(
   input  wire logic  clk,
   input  wire logic  resetn,
   exe_stage_if.slave bus
);

   es_state_e          state_q, state_d;
   logic               es_valid_q, es_valid_d;
   es_payload_t        pl_q, pl_d;
   logic [ES_XLEN-1:0] es_result_q, es_result_d;

   logic ready_go;
   logic allowin;
   logic accept;

   always_comb begin
      ready_go = (state_q == DONE) | ((state_q == BUSY) & bus.alu_complete);
      allowin  = ~es_valid_q | (ready_go & bus.ms_allowin);
      accept   = bus.ds_to_es_valid & allowin & ~bus.flush;
   end

   always_comb begin
      state_d     = state_q;
      es_valid_d  = es_valid_q;
      pl_d        = pl_q;
      es_result_d = es_result_q;
      if (bus.flush) begin
         state_d    = IDLE;
         es_valid_d = 1'b0;
      end else if (accept) begin
         state_d           = BUSY;
         es_valid_d        = 1'b1;
         pl_d.op           = bus.ds_alu_op;
         pl_d.src1         = bus.ds_src1;
         pl_d.src2         = bus.ds_src2;
         pl_d.pc           = bus.ds_pc;
         pl_d.st_data      = bus.ds_st_data;
         pl_d.dest         = bus.ds_dest;
         pl_d.gr_we        = bus.ds_gr_we;
         pl_d.res_from_mem = bus.ds_res_from_mem;
         pl_d.mem_we       = bus.ds_mem_we;
      end else if (allowin) begin
         state_d    = IDLE;
         es_valid_d = 1'b0;
      end else if ((state_q == BUSY) & bus.alu_complete) begin
         // Memory stage is stalled: capture the result so the ALU can be released.
         state_d     = DONE;
         es_result_d = bus.alu_result;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         es_valid_q  <= 1'b0;
         pl_q        <= '0;
         es_result_q <= '0;
      end else begin
         state_q     <= state_d;
         es_valid_q  <= es_valid_d;
         pl_q        <= pl_d;
         es_result_q <= es_result_d;
      end
   end

   // Dropping the op aborts an in-flight mul/div and stops a restart after DONE.
   assign bus.alu_op   = ((state_q == BUSY) & ~bus.flush) ? pl_q.op : '0;
   assign bus.alu_src1 = pl_q.src1;
   assign bus.alu_src2 = pl_q.src2;

   assign bus.es_allowin     = allowin;
   assign bus.es_to_ms_valid = es_valid_q & ready_go & ~bus.flush;
   assign bus.es_result      = (state_q == DONE) ? es_result_q :
                               (state_q == BUSY) ? bus.alu_result : '0;

   assign bus.es_pc           = pl_q.pc;
   assign bus.es_st_data      = pl_q.st_data;
   assign bus.es_dest         = pl_q.dest;
   assign bus.es_gr_we        = pl_q.gr_we;
   assign bus.es_res_from_mem = pl_q.res_from_mem;
   assign bus.es_mem_we       = pl_q.mem_we;

   assign bus.es_fwd_valid = es_valid_q & pl_q.gr_we & (pl_q.dest != '0);
   assign bus.es_fwd_dest  = pl_q.dest;
   assign bus.es_fwd_stall = es_valid_q &
                             (pl_q.res_from_mem | ((state_q == BUSY) & ~bus.alu_complete));

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_exe_stage : randomized and directed bench for exe_stage                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_exe_stage;
   import exe_stage_pkg::*;

   typedef struct {
      int          op;
      logic [31:0] a, b, pc, st;
      logic [4:0]  dest;
      bit          gwe, rfm, mwe;
   } instr_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   exe_stage_if bus ();
   exe_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

   int n_checks = 0;
   int n_err    = 0;
   int stall_cnt = 0;

   // Reference view of the stage: one held instruction and its age in the stage.
   bit          h_v = 1'b0;
   instr_t      h;
   int          h_age, h_lat;
   logic [31:0] h_res;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [ES_OP_W-1:0] onehot(input int idx);
      logic [ES_OP_W-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   function automatic int op_index(input logic [ES_OP_W-1:0] op);
      for (int i = 0; i < ES_OP_W; i++) if (op[i]) return i;
      return -1;
   endfunction

   function automatic int op_latency(input int idx);
      if (idx >= OP_DIV) return 34;
      if (idx >= OP_MUL) return 3;
      return 1;
   endfunction

   function automatic logic [31:0] alu_calc(input int idx, input logic [31:0] a, input logic [31:0] b);
      longint      s;
      logic [63:0] u;
      s = longint'($signed(a)) * longint'($signed(b));
      u = {32'd0, a} * {32'd0, b};
      case (idx)
         OP_ADD:   return a + b;
         OP_SUB:   return a - b;
         OP_SLT:   return {31'd0, $signed(a) < $signed(b)};
         OP_SLTU:  return {31'd0, a < b};
         OP_AND:   return a & b;
         OP_NOR:   return ~(a | b);
         OP_OR:    return a | b;
         OP_XOR:   return a ^ b;
         OP_SLL:   return a << b[4:0];
         OP_SRL:   return a >> b[4:0];
         OP_SRA:   return $signed(a) >>> b[4:0];
         OP_LUI:   return b;
         OP_MUL:   return u[31:0];
         OP_MULH:  return s[63:32];
         OP_MULHU: return u[63:32];
         OP_DIV:   return (b == 0) ? 32'd0 : 32'($signed(a) / $signed(b));
         OP_DIVU:  return (b == 0) ? 32'd0 : a / b;
         OP_MOD:   return (b == 0) ? 32'd0 : 32'($signed(a) % $signed(b));
         OP_MODU:  return (b == 0) ? 32'd0 : a % b;
         default:  return 32'd0;
      endcase
   endfunction

   // Shared ALU stand-in: counts consecutive enabled cycles, restarts after completion.
   int alu_cnt;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) alu_cnt <= 0;
      else if (bus.alu_op == '0 || bus.alu_complete) alu_cnt <= 0;
      else alu_cnt <= alu_cnt + 1;
   end
   assign bus.alu_complete = (op_index(bus.alu_op) >= 0) &&
                             (alu_cnt >= op_latency(op_index(bus.alu_op)) - 1);
   assign bus.alu_result   = bus.alu_complete ?
                             alu_calc(op_index(bus.alu_op), bus.alu_src1, bus.alu_src2) : 32'hDEADBEEF;

   function automatic instr_t mk(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] dest, input bit rfm);
      instr_t i;
      i.op = op; i.a = a; i.b = b; i.dest = dest; i.rfm = rfm;
      i.pc = $urandom; i.st = $urandom; i.gwe = 1'b1; i.mwe = 1'b0;
      return i;
   endfunction

   function automatic instr_t rand_ins();
      instr_t i;
      i.op   = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 11)) : int'($urandom_range(12, 18));
      i.a    = $urandom;
      i.b    = (i.op >= OP_DIV) ? 32'($urandom_range(1, 1000)) : $urandom;
      i.pc   = $urandom;
      i.st   = $urandom;
      i.dest = 5'($urandom);
      i.gwe  = 1'($urandom);
      i.rfm  = ($urandom_range(0, 9) == 0);
      i.mwe  = 1'($urandom);
      return i;
   endfunction

   task automatic cycle(input bit dv, input instr_t ins, input bit ms, input bit fl);
      bit busy, ready, exp_allow;
      @(negedge clk);
      bus.ds_to_es_valid  = dv;
      bus.ds_alu_op       = onehot(ins.op);
      bus.ds_src1         = ins.a;
      bus.ds_src2         = ins.b;
      bus.ds_pc           = ins.pc;
      bus.ds_dest         = ins.dest;
      bus.ds_gr_we        = ins.gwe;
      bus.ds_res_from_mem = ins.rfm;
      bus.ds_mem_we       = ins.mwe;
      bus.ds_st_data      = ins.st;
      bus.ms_allowin      = ms;
      bus.flush           = fl;
      #1;
      busy      = h_v && (h_age < h_lat);
      // A flushed cycle drops the ALU enable, so completion cannot happen in it.
      ready     = h_v && ((h_age >= h_lat) || (h_age == h_lat - 1 && !fl));
      exp_allow = !h_v || (ready && ms);
      if (bus.es_allowin === 1'b0) stall_cnt++;
      chk("es_allowin", bus.es_allowin, exp_allow);
      chk("es_to_ms_valid", bus.es_to_ms_valid, ready && !fl);
      chk("alu_op", bus.alu_op, (busy && !fl) ? onehot(h.op) : '0);
      if (busy) begin
         chk("alu_src1", bus.alu_src1, h.a);
         chk("alu_src2", bus.alu_src2, h.b);
      end
      chk("es_fwd_valid", bus.es_fwd_valid, h_v && h.gwe && (h.dest != 0));
      chk("es_fwd_stall", bus.es_fwd_stall, h_v && (h.rfm || !ready));
      if (h_v) chk("es_fwd_dest", bus.es_fwd_dest, h.dest);
      if (ready && !fl) begin
         chk("es_result", bus.es_result, h_res);
         chk("es_pc", bus.es_pc, h.pc);
         chk("es_dest", bus.es_dest, h.dest);
         chk("es_st_data", bus.es_st_data, h.st);
         chk("es_flags", {bus.es_gr_we, bus.es_res_from_mem, bus.es_mem_we}, {h.gwe, h.rfm, h.mwe});
      end
      @(posedge clk);
      if (fl) h_v = 1'b0;
      else if (dv && exp_allow) begin
         h = ins; h_v = 1'b1; h_age = 0;
         h_lat = op_latency(ins.op);
         h_res = alu_calc(ins.op, ins.a, ins.b);
      end else if (exp_allow) h_v = 1'b0;
      else h_age++;
   endtask

   instr_t idle;

   initial begin
      idle = mk(OP_ADD, 0, 0, 0, 0);
      bus.ds_to_es_valid = 0; bus.ds_alu_op = '0; bus.ds_src1 = '0; bus.ds_src2 = '0;
      bus.ds_pc = '0; bus.ds_dest = '0; bus.ds_gr_we = 0; bus.ds_res_from_mem = 0;
      bus.ds_mem_we = 0; bus.ds_st_data = '0; bus.ms_allowin = 1; bus.flush = 0;
      #2;
      chk("rst_allowin", bus.es_allowin, 1);
      chk("rst_to_ms", bus.es_to_ms_valid, 0);
      chk("rst_alu_op", bus.alu_op, 0);
      chk("rst_result", bus.es_result, 0);
      chk("rst_pc", bus.es_pc, 0);
      chk("rst_fwd", {bus.es_fwd_valid, bus.es_fwd_stall}, 0);
      @(negedge clk); @(negedge clk);
      resetn = 1'b1;

      // Back-to-back adds
      cycle(1, mk(OP_ADD, 3, 4, 7, 0), 1, 0);
      cycle(1, mk(OP_ADD, 5, 6, 8, 0), 1, 0);
      cycle(0, idle, 1, 0);
      cycle(0, idle, 1, 0);

      // Signed divide -7/2 with a 34-cycle ALU
      stall_cnt = 0;
      cycle(1, mk(OP_DIV, 32'hFFFF_FFF9, 2, 9, 0), 1, 0);
      for (int i = 0; i < 36; i++) cycle(0, idle, 1, 0);
      chk("div_stall_cycles", stall_cnt, 33);

      // mulhu under memory-stage backpressure
      cycle(1, mk(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 0), 1, 0);
      cycle(0, idle, 1, 0);
      for (int i = 0; i < 6; i++) cycle(0, idle, 0, 0);
      cycle(0, idle, 1, 0);
      cycle(0, idle, 1, 0);

      // Flush during mod with a coinciding decode offer
      cycle(1, mk(OP_MOD, 32'hFFFF_FFEF, 5, 11, 0), 1, 0);
      for (int i = 0; i < 3; i++) cycle(0, idle, 1, 0);
      cycle(1, mk(OP_ADD, 1, 2, 12, 0), 1, 1);
      cycle(0, idle, 1, 0);
      cycle(0, idle, 1, 0);

      // Load forwarding, r5 then r0
      cycle(1, mk(OP_ADD, 32'h100, 4, 5, 1), 0, 0);
      cycle(0, idle, 0, 0);
      cycle(1, mk(OP_ADD, 32'h100, 4, 0, 1), 1, 0);
      cycle(0, idle, 1, 0);
      cycle(0, idle, 1, 0);

      // Asynchronous reset while a divide is in flight
      cycle(1, mk(OP_DIV, 100, 7, 13, 0), 1, 0);
      for (int i = 0; i < 5; i++) cycle(0, idle, 1, 0);
      @(negedge clk);
      bus.ds_to_es_valid = 0;
      #1 resetn = 1'b0;
      #1;
      chk("rstmid_to_ms", bus.es_to_ms_valid, 0);
      chk("rstmid_alu_op", bus.alu_op, 0);
      chk("rstmid_fwd_valid", bus.es_fwd_valid, 0);
      h_v = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #1 chk("rstmid_allowin", bus.es_allowin, 1);
      cycle(0, idle, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 9) < 6, rand_ins(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 24) == 0);
      for (int i = 0; i < 40; i++) cycle(0, idle, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
